// File: rtl/msk_pkg.sv
// Shared defaults and wave-table helpers for the MSK phase generator.
package msk_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_ACC_W     = 26;
    localparam int DEF_LUT_AW    = 8;
    localparam int DEF_ALIGN_DLY = 10;
    localparam int DEF_AHEAD_DLY = 5;
    localparam int NCO_LAT       = 3;

    localparam longint HALF_PI_Q30 = 64'sd1686629713;

    function automatic int tbl_peak(input int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    // round(peak * sin(pi/2 * k / 2^aw)), Taylor series in Q30 fixed point
    function automatic int quarter_sin(input int k, input int aw, input int dw);
        longint x;
        longint x2;
        longint term;
        longint acc;
        longint v;
        longint pk;
        pk   = longint'(tbl_peak(dw));
        x    = (HALF_PI_Q30 * longint'(k)) >>> aw;
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int n = 1; n <= 8; n++) begin
            term = -((term * x2) >>> 30) / longint'(2 * n * (2 * n + 1));
            acc  = acc + term;
        end
        v = (acc * pk + (64'sd1 <<< 29)) >>> 30;
        if (v < 0) v = 0;
        if (v > pk) v = pk;
        return int'(v);
    endfunction

endpackage

// File: rtl/msk_sincos_lut.sv
// Quarter-wave sine table with quadrant fold; phase in, cos/sin out after 2 clocks.
module msk_sincos_lut
    import msk_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LUT_AW = DEF_LUT_AW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LUT_AW+1:0]        phase_in,
    output logic signed [DATA_W-1:0] cos_out,
    output logic signed [DATA_W-1:0] sin_out
);

    localparam int N = 2 ** LUT_AW;
    localparam logic [DATA_W-1:0] PEAK = DATA_W'(tbl_peak(DATA_W));

    logic [DATA_W-1:0] rom [N];

    for (genvar k = 0; k < N; k++) begin : g_rom
        localparam logic [DATA_W-1:0] ENTRY =
            DATA_W'(quarter_sin(k, LUT_AW, DATA_W));
        assign rom[k] = ENTRY;
    end

    logic [1:0]        quad_s;
    logic [1:0]        quad_c;
    logic [LUT_AW-1:0] addr;
    logic [LUT_AW-1:0] mirr;
    logic [DATA_W-1:0] fwd;
    logic [DATA_W-1:0] rev;

    logic [DATA_W-1:0] mag_s_q, mag_s_d;
    logic [DATA_W-1:0] mag_c_q, mag_c_d;
    logic              neg_s_q, neg_s_d;
    logic              neg_c_q, neg_c_d;
    logic signed [DATA_W-1:0] sin_q, sin_d;
    logic signed [DATA_W-1:0] cos_q, cos_d;

    assign quad_s = phase_in[LUT_AW+1:LUT_AW];
    assign quad_c = quad_s + 2'd1;
    assign addr   = phase_in[LUT_AW-1:0];
    assign mirr   = -addr;
    assign fwd    = rom[addr];
    // Mirrored address 0 lands on the quarter point, one past the table end
    assign rev    = (addr == '0) ? PEAK : rom[mirr];

    always_comb begin
        mag_s_d = quad_s[0] ? rev : fwd;
        mag_c_d = quad_c[0] ? rev : fwd;
        neg_s_d = quad_s[1];
        neg_c_d = quad_c[1];
        sin_d   = neg_s_q ? -$signed(mag_s_q) : $signed(mag_s_q);
        cos_d   = neg_c_q ? -$signed(mag_c_q) : $signed(mag_c_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_s_q <= '0;
            mag_c_q <= '0;
            neg_s_q <= 1'b0;
            neg_c_q <= 1'b0;
            sin_q   <= '0;
            cos_q   <= '0;
        end else begin
            mag_s_q <= mag_s_d;
            mag_c_q <= mag_c_d;
            neg_s_q <= neg_s_d;
            neg_c_q <= neg_c_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
        end
    end

    assign sin_out = sin_q;
    assign cos_out = cos_q;

endmodule

// File: rtl/msk_phase_gen.sv
// MSK burst phase generator: aligned pulse/IQ delay lines, NCO, weighting, pulse count.
module msk_phase_gen
    import msk_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int LUT_AW    = DEF_LUT_AW,
    parameter int ALIGN_DLY = DEF_ALIGN_DLY,
    parameter int AHEAD_DLY = DEF_AHEAD_DLY
) (
    input  logic                     clk_msk_in,
    input  logic                     logic_rst_in,
    input  logic                     phase_pulse_in,
    input  logic                     phase_i_in,
    input  logic                     phase_q_in,
    input  logic [ACC_W-1:0]         freq_word_in,
    input  logic                     freq_we_in,
    output logic                     phase_vaild_ahead,
    output logic                     phase_vaild_out,
    output logic signed [DATA_W-1:0] phase_cos_out,
    output logic signed [DATA_W-1:0] phase_sin_out,
    output logic [15:0]              pulse_cnt_out
);

    localparam int PW = LUT_AW + 2;

    logic                 blk_q, blk_d;
    logic                 pulse_eff;
    logic [ALIGN_DLY:1]   pdly_q, pdly_d;
    logic [ALIGN_DLY:1]   idly_q, idly_d;
    logic [ALIGN_DLY:1]   qdly_q, qdly_d;
    logic [ALIGN_DLY:0]   pulse_dly;
    logic                 nco_en;
    logic                 inc_load;
    logic [ACC_W-1:0]     pend_q, pend_d;
    logic [ACC_W-1:0]     act_q, act_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic signed [DATA_W-1:0] lut_cos, lut_sin;
    logic signed [DATA_W-1:0] cos_w, sin_w;
    logic signed [DATA_W-1:0] cos_q, cos_d;
    logic signed [DATA_W-1:0] sin_q, sin_d;
    logic                 vld_q, vld_d;
    logic [15:0]          cnt_q, cnt_d;

    // After reset the gate stays shut until the pulse input is seen low
    assign pulse_eff = phase_pulse_in & ~blk_q;
    assign pulse_dly = {pdly_q, pulse_eff};
    assign nco_en    = pulse_dly[ALIGN_DLY-NCO_LAT];
    assign inc_load  = nco_en & ~pulse_dly[ALIGN_DLY-NCO_LAT+1];

    always_comb begin
        blk_d  = blk_q & phase_pulse_in;
        pdly_d = {pdly_q[ALIGN_DLY-1:1], pulse_eff};
        idly_d = {idly_q[ALIGN_DLY-1:1], phase_i_in};
        qdly_d = {qdly_q[ALIGN_DLY-1:1], phase_q_in};
        pend_d = freq_we_in ? freq_word_in : pend_q;
        act_d  = act_q;
        if (inc_load) begin
            act_d = freq_we_in ? freq_word_in : pend_q;
        end
        // Load cycle parks the accumulator at 0 so phase 0 is the first sample
        acc_d  = (nco_en && !inc_load) ? acc_q + act_q : '0;
        cos_w  = idly_q[ALIGN_DLY] ? lut_cos : -lut_cos;
        sin_w  = qdly_q[ALIGN_DLY] ? lut_sin : -lut_sin;
        vld_d  = pdly_q[ALIGN_DLY];
        cos_d  = vld_d ? cos_w : '0;
        sin_d  = vld_d ? sin_w : '0;
        cnt_d  = (vld_q && !vld_d) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk_msk_in or posedge logic_rst_in) begin
        if (logic_rst_in) begin
            blk_q  <= 1'b1;
            pdly_q <= '0;
            idly_q <= '0;
            qdly_q <= '0;
            pend_q <= '0;
            act_q  <= '0;
            acc_q  <= '0;
            cos_q  <= '0;
            sin_q  <= '0;
            vld_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            blk_q  <= blk_d;
            pdly_q <= pdly_d;
            idly_q <= idly_d;
            qdly_q <= qdly_d;
            pend_q <= pend_d;
            act_q  <= act_d;
            acc_q  <= acc_d;
            cos_q  <= cos_d;
            sin_q  <= sin_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
        end
    end

    msk_sincos_lut #(
        .DATA_W (DATA_W),
        .LUT_AW (LUT_AW)
    ) u_lut (
        .clk      (clk_msk_in),
        .rst      (logic_rst_in),
        .phase_in (acc_q[ACC_W-1 -: PW]),
        .cos_out  (lut_cos),
        .sin_out  (lut_sin)
    );

    assign phase_vaild_ahead = pulse_dly[AHEAD_DLY];
    assign phase_vaild_out   = vld_q;
    assign phase_cos_out     = cos_q;
    assign phase_sin_out     = sin_q;
    assign pulse_cnt_out     = cnt_q;

endmodule

// File: tb/tb_msk_phase_gen.sv
// Scoreboard bench for msk_phase_gen: default instance plus a short-alignment one.
module tb_msk_phase_gen;

    localparam int AW    = 26;
    localparam int ALIGN = 10;

    typedef struct {
        int c;
        int s;
        int tol;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pulse = 1'b0;
    logic i_b = 1'b1;
    logic q_b = 1'b1;
    logic we = 1'b0;
    logic [AW-1:0] word = '0;

    logic ahead, vld, ahead2, vld2;
    logic signed [15:0] cos_o, sin_o, cos2, sin2;
    logic [15:0] cnt, cnt2;

    int errors = 0;
    int checks = 0;
    exp_t sb[$];
    longint pend_m = 0;

    always #5 clk = ~clk;

    msk_phase_gen dut (
        .clk_msk_in        (clk),
        .logic_rst_in      (rst),
        .phase_pulse_in    (pulse),
        .phase_i_in        (i_b),
        .phase_q_in        (q_b),
        .freq_word_in      (word),
        .freq_we_in        (we),
        .phase_vaild_ahead (ahead),
        .phase_vaild_out   (vld),
        .phase_cos_out     (cos_o),
        .phase_sin_out     (sin_o),
        .pulse_cnt_out     (cnt)
    );

    msk_phase_gen #(
        .ALIGN_DLY (6),
        .AHEAD_DLY (2)
    ) dut2 (
        .clk_msk_in        (clk),
        .logic_rst_in      (rst),
        .phase_pulse_in    (pulse),
        .phase_i_in        (i_b),
        .phase_q_in        (q_b),
        .freq_word_in      (word),
        .freq_we_in        (we),
        .phase_vaild_ahead (ahead2),
        .phase_vaild_out   (vld2),
        .phase_cos_out     (cos2),
        .phase_sin_out     (sin2),
        .pulse_cnt_out     (cnt2)
    );

    function automatic exp_t model(input longint acc, input bit ib,
                                   input bit qb, input int tol);
        exp_t e;
        real  ang;
        int   ph;
        ph    = int'(acc >>> (AW - 10));
        ang   = 2.0 * 3.14159265358979 * real'(ph) / 1024.0;
        e.c   = int'(32767.0 * $cos(ang));
        e.s   = int'(32767.0 * $sin(ang));
        if (!ib) e.c = -e.c;
        if (!qb) e.s = -e.s;
        e.tol = tol;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        int dc;
        int ds;
        if (vld === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_underflow: got cos=%0d sin=%0d, none expected",
                       cos_o, sin_o);
            end
            if (sb.size() != 0) begin
                e  = sb.pop_front();
                dc = int'(cos_o) - e.c;
                ds = int'(sin_o) - e.s;
                if (dc < 0) dc = -dc;
                if (ds < 0) ds = -ds;
                checks++;
                assert (dc <= e.tol) else begin
                    errors++;
                    $error("FAIL cos: got %0d want %0d tol %0d", cos_o, e.c, e.tol);
                end
                checks++;
                assert (ds <= e.tol) else begin
                    errors++;
                    $error("FAIL sin: got %0d want %0d tol %0d", sin_o, e.s, e.tol);
                end
                checks++;
                assert (cos_o !== -16'sd32768 && sin_o !== -16'sd32768) else begin
                    errors++;
                    $error("FAIL no_min: got cos=%0d sin=%0d", cos_o, sin_o);
                end
            end
        end else begin
            checks++;
            assert ({cos_o, sin_o} === 32'd0) else begin
                errors++;
                $error("FAIL zero_fill: got cos=%0d sin=%0d want 0", cos_o, sin_o);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic load_word(input longint w);
        word = AW'(w);
        we   = 1'b1;
        tick();
        we   = 1'b0;
        pend_m = w;
    endtask

    task automatic idle(input int n);
        pulse = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        pend_m = 0;
        tick();
        rst = 1'b0;
        tick();
        tick();
    endtask

    task automatic run_pulse(input int len, input bit ib, input bit qb,
                             input int we_at, input longint we_word,
                             input bit chk_tim);
        longint inc;
        longint acc;
        int     c;
        inc = (we_at >= 0 && we_at <= ALIGN - 3) ? we_word : pend_m;
        for (int n = 0; n < len; n++) begin
            pulse = 1'b1;
            i_b   = ib;
            q_b   = qb;
            if (n == we_at) begin
                word = AW'(we_word);
                we   = 1'b1;
            end else begin
                we   = 1'b0;
            end
            acc = (longint'(n) * inc) % (64'sd1 <<< AW);
            sb.push_back(model(acc, ib, qb, (n == 0) ? 0 : 2));
            tick();
            if (chk_tim && n < 12) begin
                c = n + 1;
                chk("ahead_lat", int'(ahead), int'(c >= 5));
                chk("valid_lat", int'(vld), int'(c >= 11));
                chk("ahead2_lat", int'(ahead2), int'(c >= 2));
                chk("valid2_lat", int'(vld2), int'(c >= 7));
                if (c == 7) begin
                    chk("cos2_first", int'(cos2), 32767);
                    chk("sin2_first", int'(sin2), 0);
                end
            end
        end
        we    = 1'b0;
        pulse = 1'b0;
        if (we_at >= 0) pend_m = we_word;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        chk("rst_valid", int'(vld), 0);
        chk("rst_ahead", int'(ahead), 0);
        chk("rst_cos", int'(cos_o), 0);
        chk("rst_sin", int'(sin_o), 0);
        chk("rst_cnt", int'(cnt), 0);
        rst = 1'b0;
        tick();
        tick();
        load_word(1677722);
        tick();

        // I=Q=1 with latency checks on both instances
        run_pulse(200, 1'b1, 1'b1, -1, 0, 1'b1);
        idle(20);
        chk("drain1", sb.size(), 0);
        chk("cnt_a", int'(cnt), 1);
        chk("cnt2_a", int'(cnt2), 1);

        // I=0 inverts cosine
        run_pulse(200, 1'b0, 1'b1, -1, 0, 1'b0);
        idle(20);
        chk("drain2", sb.size(), 0);
        chk("cnt_b", int'(cnt), 2);

        // 100 on / 50 off / 100 on from a fresh reset
        do_reset();
        chk("cnt_rst", int'(cnt), 0);
        load_word(1677722);
        run_pulse(100, 1'b1, 1'b1, -1, 0, 1'b0);
        idle(50);
        run_pulse(100, 1'b1, 1'b1, -1, 0, 1'b0);
        idle(20);
        chk("drain3", sb.size(), 0);
        chk("cnt_c", int'(cnt), 2);

        // single-cycle gap restarts phase
        run_pulse(40, 1'b1, 1'b0, -1, 0, 1'b0);
        idle(1);
        run_pulse(40, 1'b0, 1'b0, -1, 0, 1'b0);
        idle(20);
        chk("drain4", sb.size(), 0);
        chk("cnt_d", int'(cnt), 4);

        // mid-pulse write takes effect next pulse; write on load edge is immediate
        run_pulse(200, 1'b1, 1'b1, 100, 3355444, 1'b0);
        idle(20);
        run_pulse(100, 1'b1, 1'b1, -1, 0, 1'b0);
        idle(20);
        run_pulse(60, 1'b1, 1'b1, ALIGN - 3, 1677722, 1'b0);
        idle(20);
        chk("drain5", sb.size(), 0);
        chk("cnt_e", int'(cnt), 7);

        // reset at clock 50 of a pulse, pulse input held high
        run_pulse(50, 1'b1, 1'b1, -1, 0, 1'b0);
        pulse = 1'b1;
        rst   = 1'b1;
        sb.delete();
        pend_m = 0;
        #1;
        chk("abort_valid", int'(vld), 0);
        chk("abort_ahead", int'(ahead), 0);
        chk("abort_cos", int'(cos_o), 0);
        chk("abort_sin", int'(sin_o), 0);
        chk("abort_cnt", int'(cnt), 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("held_valid", int'(vld), 0);
            chk("held_ahead", int'(ahead), 0);
        end
        idle(2);
        load_word(1677722);
        run_pulse(60, 1'b1, 1'b1, -1, 0, 1'b0);
        idle(20);
        chk("drain6", sb.size(), 0);
        chk("cnt_f", int'(cnt), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/msk_phase_gen.md
MSK_PHASE_GEN -- requirements
Module: msk_phase_gen

Interface
REQ-001 Parameter DATA_W, default 16: output sample width, signed two's complement.
REQ-002 Parameter ACC_W, default 26: phase accumulator width; the top LUT_AW+2 bits address the wave table.
REQ-003 Parameter LUT_AW, default 8: quarter-wave table address bits (2^LUT_AW entries).
REQ-004 Parameter ALIGN_DLY, default 10: pulse/data-to-weighting alignment delay in clocks; legal range 4..31.
REQ-005 Parameter AHEAD_DLY, default 5: delay applied to phase_vaild_ahead; legal range 0..ALIGN_DLY.
REQ-006 Port clk_msk_in, input, 1: sole clock.
REQ-007 Port logic_rst_in, input, 1: reset, asynchronous, active-high.
REQ-008 Port phase_pulse_in, input, 1: burst gate; high while a pulse is transmitted.
REQ-009 Port phase_i_in, input, 1: I bit (1 -> +1, 0 -> -1).
REQ-010 Port phase_q_in, input, 1: Q bit (1 -> +1, 0 -> -1).
REQ-011 Port freq_word_in, input, ACC_W: NCO increment request.
REQ-012 Port freq_we_in, input, 1: single-cycle strobe that loads freq_word_in into the pending register.
REQ-013 Port phase_vaild_ahead, output, 1: phase_pulse_in delayed by AHEAD_DLY.
REQ-014 Port phase_vaild_out, output, 1: qualifies the output samples.
REQ-015 Port phase_cos_out, output, DATA_W: I-weighted cosine.
REQ-016 Port phase_sin_out, output, DATA_W: Q-weighted sine.
REQ-017 Port pulse_cnt_out, output, 16: count of completed pulses; wraps at 65535 -> 0.

Function
REQ-018 The phase_pulse_in, phase_i_in and phase_q_in inputs SHALL each pass through a shift register of length ALIGN_DLY (index k = delay of k clocks).
REQ-019 The pending increment SHALL be copied to the active increment only on a rising edge of pulse_dly[ALIGN_DLY-3], so the frequency never changes inside a pulse.
REQ-020 The accumulator SHALL hold 0 while pulse_dly[ALIGN_DLY-3] is 0, and SHALL add the active increment modulo 2^ACC_W each cycle while it is 1.
REQ-021 The NCO pipeline SHALL be 3 registers (accumulator, table read, quadrant fold), so that the phase-0 sample meets pulse_dly[ALIGN_DLY] and i/q_dly[ALIGN_DLY].
REQ-022 The quadrant fold SHALL derive cosine and sine from the quarter table using table address mirroring and sign inversion.
REQ-023 The table peak SHALL be 2^(DATA_W-1)-1, and the value -2^(DATA_W-1) SHALL never be produced.
REQ-024 The weighted cosine SHALL be cos when i_dly[ALIGN_DLY]=1, otherwise its exact two's-complement negation; the weighted sine SHALL use q_dly[ALIGN_DLY] the same way.
REQ-025 When pulse_dly[ALIGN_DLY]=1, the output registers SHALL load the weighted values; otherwise they SHALL load 0 (zero fill).
REQ-026 phase_vaild_out SHALL equal pulse_dly[ALIGN_DLY] registered once, giving a total latency of ALIGN_DLY+1 from phase_pulse_in.
REQ-027 pulse_cnt_out SHALL increment on each falling edge of phase_vaild_out.
REQ-028 If freq_we_in and the load edge of REQ-019 occur in the same cycle, the new freq_word_in SHALL become active directly.
REQ-029 A one-cycle gap between pulses SHALL reset the phase, and the next pulse SHALL restart at phase 0.

Reset
REQ-030 Asserting logic_rst_in SHALL immediately clear all delay lines, the accumulator, the pending and active increments, pulse_cnt_out, phase_vaild_out, phase_vaild_ahead, phase_cos_out and phase_sin_out.
REQ-031 Reset asserted mid-pulse SHALL abort the pulse, which SHALL not be counted; after release, output SHALL resume only on a new rising edge of phase_pulse_in.

Structure
REQ-032 A shared package msk_pkg SHALL hold the default parameters, NCO_LAT=3, and a function computing the table peak.
REQ-033 The quarter-wave ROM plus fold SHALL be sub-module msk_sincos_lut (registered address in, registered cos/sin out, 2-cycle latency).
REQ-034 The accumulator, delay lines, weighting and counter SHALL reside in the top level.

Verification
REQ-035 Defaults, freq_word 1677722 (40 clk/cycle), pulse high 200 clk, I=Q=1 -> first valid cycle gives cos=32767, sin=0; cycle +10 gives cos~0, sin~32767 (±2 LSB).
REQ-036 I=0, Q=1 with the same stimulus -> first valid cos=-32767; no output sample ever equals -32768.
REQ-037 Pulse high 100 clk, low 50 clk, high 100 clk -> outputs are 0 during the gap, the second pulse restarts with cos=32767, and pulse_cnt_out=2.
REQ-038 freq_we_in pulsed mid-pulse with 3355444 -> period unchanged (40 clk) until the next pulse, where the period becomes 20 clk.
REQ-039 logic_rst_in asserted at clock 50 of a pulse -> all outputs are 0 in the same cycle, pulse_cnt_out=0, and no output appears until a fresh pulse edge.
REQ-040 ALIGN_DLY=6, AHEAD_DLY=2 -> phase_vaild_ahead rises 2 clk and phase_vaild_out rises 7 clk after phase_pulse_in.
